// File: rtl/fsm_twoscomp_pkg.sv
// Shared definitions for the word-framed serial two's-complementer.
package fsm_twoscomp_pkg;

    typedef enum logic {
        ST_COPY   = 1'b0,
        ST_INVERT = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fsm_twoscomp_bitcnt.sv
// Bit-position counter within a word: wraps after WIDTH-1, advances only when enabled.
module fsm_twoscomp_bitcnt
    import fsm_twoscomp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic first_o,
    output logic last_o
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/fsm_mealy_twoscomp_word.sv
// Word-framed LSB-first serial two's-complementer with Mealy output.
// Define FSM_TWOSCOMP_STATUS_EN to build the ovf/zero status registers.
module fsm_mealy_twoscomp_word
    import fsm_twoscomp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic A_in,
    input  logic valid_in,
    input  logic negate_in,
    output logic N_out,
    output logic valid_out,
    output logic last_out,
    output logic ovf_out,
    output logic zero_out
);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   mode;
    logic   first_bit, last_bit;

    fsm_twoscomp_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .en_i    (valid_in),
        .first_o (first_bit),
        .last_o  (last_bit)
    );

    // On bit 0 the mode comes straight from negate_in so the first bit needs no latency.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mode    = first_bit ? negate_in : mode_q;
        N_out   = 1'b0;
        if (valid_in) begin
            N_out = (mode && (state_q == ST_INVERT)) ? ~A_in : A_in;
            if (first_bit) begin
                mode_d = negate_in;
            end
            if (last_bit) begin
                state_d = ST_COPY;
            end else if (A_in) begin
                state_d = ST_INVERT;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_COPY;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign valid_out = valid_in;
    assign last_out  = valid_in & last_bit;

`ifdef FSM_TWOSCOMP_STATUS_EN
    logic ovf_q, ovf_d, zero_q, zero_d;
    logic word_end_copy;

    // Still in ST_COPY on the last bit means no 1 arrived in bits 0..WIDTH-2.
    always_comb begin
        word_end_copy = valid_in && last_bit && (state_q == ST_COPY);
        ovf_d         = word_end_copy && mode && A_in;
        zero_d        = word_end_copy && !A_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf_out  = ovf_q;
    assign zero_out = zero_q;
`else
    assign ovf_out  = 1'b0;
    assign zero_out = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_mealy_twoscomp_word.sv
// Scoreboard bench for fsm_mealy_twoscomp_word at WIDTH 8, 2 and 16.
module tb_fsm_mealy_twoscomp_word;

`ifdef FSM_TWOSCOMP_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] word;
        bit          ovf;
        bit          zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a_in = '0, v_in = '0, n_in = '0;
    logic [2:0] n_o, v_o, l_o, ovf_o, zr_o;

    exp_t q0[$], q1[$], q2[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   done    = 1'b0;
    bit   fin     = 1'b0;

    int unsigned bitpos [3];
    logic [63:0] acc    [3];
    bit          pend   [3];
    exp_t        cur    [3];

    always #5 clk = ~clk;

    fsm_mealy_twoscomp_word #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .A_in(a_in[0]), .valid_in(v_in[0]), .negate_in(n_in[0]),
        .N_out(n_o[0]), .valid_out(v_o[0]), .last_out(l_o[0]), .ovf_out(ovf_o[0]), .zero_out(zr_o[0])
    );
    fsm_mealy_twoscomp_word #(.WIDTH(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .A_in(a_in[1]), .valid_in(v_in[1]), .negate_in(n_in[1]),
        .N_out(n_o[1]), .valid_out(v_o[1]), .last_out(l_o[1]), .ovf_out(ovf_o[1]), .zero_out(zr_o[1])
    );
    fsm_mealy_twoscomp_word #(.WIDTH(16)) dut16 (
        .clk_in(clk), .rst_in(rst), .A_in(a_in[2]), .valid_in(v_in[2]), .negate_in(n_in[2]),
        .N_out(n_o[2]), .valid_out(v_o[2]), .last_out(l_o[2]), .ovf_out(ovf_o[2]), .zero_out(zr_o[2])
    );

    function automatic int unsigned wof(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    function automatic logic [63:0] wmask(input int unsigned w);
        logic [63:0] one;
        one = 64'd1;
        return (w >= 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s [W%0d] t=%0t: got %0h expected %0h", nm, wof(i), $time, act, expv);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input int i, input bit v, input bit a, input bit n);
        v_in[i] = v;
        a_in[i] = a;
        n_in[i] = n;
        @(posedge clk);
        #1;
        v_in[i] = 1'b0;
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic send_word(input int i, input logic [63:0] x, input bit neg,
                             input logic [63:0] ew, input bit eovf, input bit ezero,
                             input int gap_at, input int gap_len, input bit rnd_gaps);
        exp_t e;
        int unsigned w;
        w = wof(i);
        e.word = ew;
        e.ovf  = STAT & eovf;
        e.zero = STAT & ezero;
        push(i, e);
        for (int unsigned b = 0; b < w; b++) begin
            if (int'(b) == gap_at) begin
                repeat (gap_len) cyc(i, 1'b0, 1'b1, 1'b1);
            end
            if (rnd_gaps && $urandom_range(3) == 0) begin
                repeat ($urandom_range(2, 1)) cyc(i, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            // negate_in toggled on bits 1.. to show it is ignored there
            cyc(i, 1'b1, x[b], (b == 0) ? neg : ~neg);
        end
    endtask

    task automatic sweep_word(input int i, input logic [63:0] x, input bit neg);
        int unsigned w;
        logic [63:0] m, r;
        w = wof(i);
        m = wmask(w);
        r = neg ? ((~x + 64'd1) & m) : (x & m);
        send_word(i, x, neg, r, neg && ((x & m) == (64'd1 << (w - 1))), (x & m) == 64'd0, -1, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0);

        // WIDTH=8 directed vectors (hand-computed)
        send_word(0, 64'h06, 1'b1, 64'hFA, 1'b0, 1'b0, -1, 0, 1'b0);
        send_word(0, 64'h06, 1'b0, 64'h06, 1'b0, 1'b0, -1, 0, 1'b0);
        send_word(0, 64'h01, 1'b1, 64'hFF, 1'b0, 1'b0, -1, 0, 1'b0);
        send_word(0, 64'h80, 1'b1, 64'h80, 1'b1, 1'b0, -1, 0, 1'b0);
        send_word(0, 64'h00, 1'b1, 64'h00, 1'b0, 1'b1, -1, 0, 1'b0);
        send_word(0, 64'h80, 1'b0, 64'h80, 1'b0, 1'b0, -1, 0, 1'b0);
        send_word(0, 64'h00, 1'b0, 64'h00, 1'b0, 1'b1, -1, 0, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b0);
        send_word(0, 64'h0C, 1'b1, 64'hF4, 1'b0, 1'b0, 3, 3, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b0);

        // partial word abandoned by reset after bit 4
        for (int unsigned b = 0; b < 5; b++) begin
            cyc(0, 1'b1, 1'(b & 1), 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(0, 64'h03, 1'b1, 64'hFD, 1'b0, 1'b0, -1, 0, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b0);

        // WIDTH=2: every word in both modes, random order of modes
        for (int unsigned x = 0; x < 4; x++) begin
            bit m;
            m = 1'($urandom_range(1));
            sweep_word(1, 64'(x), m);
            sweep_word(1, 64'(x), ~m);
        end
        cyc(1, 1'b0, 1'b0, 1'b0);

        // WIDTH=16: boundary words then random words
        sweep_word(2, 64'h0000, 1'b1);
        sweep_word(2, 64'h8000, 1'b1);
        sweep_word(2, 64'h8000, 1'b0);
        sweep_word(2, 64'h0001, 1'b1);
        sweep_word(2, 64'hFFFF, 1'b1);
        sweep_word(2, 64'h0000, 1'b0);
        for (int k = 0; k < 120; k++) begin
            sweep_word(2, 64'($urandom_range(16'hFFFF)), 1'($urandom_range(1)));
        end
        repeat (3) cyc(2, 1'b0, 1'b0, 1'b0);

        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done && !fin) begin
            fin = 1'b1;
            chk("q0_drained", 0, 64'(q0.size()), 64'd0);
            chk("q1_drained", 1, 64'(q1.size()), 64'd0);
            chk("q2_drained", 2, 64'(q2.size()), 64'd0);
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                bitpos[i] = 0;
                acc[i]    = '0;
                pend[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int unsigned w;
                w = wof(i);
                if (pend[i]) begin
                    chk("ovf_pulse", i, 64'(ovf_o[i]), 64'(cur[i].ovf));
                    chk("zero_pulse", i, 64'(zr_o[i]), 64'(cur[i].zero));
                    pend[i] = 1'b0;
                end else begin
                    chk("status_idle", i, {62'd0, ovf_o[i], zr_o[i]}, 64'd0);
                end
                chk("valid_out", i, 64'(v_o[i]), 64'(v_in[i]));
                if (!v_in[i]) begin
                    chk("idle_outs", i, {62'd0, n_o[i], l_o[i]}, 64'd0);
                end else begin
                    chk("last_out", i, 64'(l_o[i]), 64'(bitpos[i] == w - 1));
                    acc[i][bitpos[i]] = n_o[i];
                    if (bitpos[i] == w - 1) begin
                        int qs;
                        case (i)
                            0:       qs = q0.size();
                            1:       qs = q1.size();
                            default: qs = q2.size();
                        endcase
                        chk("exp_available", i, 64'(qs > 0), 64'd1);
                        if (qs > 0) begin
                            case (i)
                                0:       cur[i] = q0.pop_front();
                                1:       cur[i] = q1.pop_front();
                                default: cur[i] = q2.pop_front();
                            endcase
                            chk("word", i, acc[i], cur[i].word);
                            pend[i] = 1'b1;
                        end
                        bitpos[i] = 0;
                        acc[i]    = '0;
                    end else begin
                        bitpos[i] = bitpos[i] + 1;
                    end
                end
            end
        end
    end

endmodule
